// File: rtl/mod_controller_events_pkg.sv
// mod_controller_events_pkg
//   Shared definitions for the controller event block.
//   - Event word layout: [2:0] button index, [3] release flag, [4] repeat flag.
//   - NES button indices, in the bit order the controller reader produces.
//   - Scan FSM state type and a helper that packs an event word.
package mod_controller_events_pkg;

    // Event word fields
    localparam int EVT_IDX_LSB     = 0;
    localparam int EVT_IDX_W       = 3;
    localparam int EVT_RELEASE_BIT = 3;
    localparam int EVT_REPEAT_BIT  = 4;
    localparam int EVT_W           = 5;

    localparam int NUM_BUTTONS     = 8;

    // NES button indices (controller reader shift order)
    localparam int BTN_A           = 0;
    localparam int BTN_B           = 1;
    localparam int BTN_SELECT      = 2;
    localparam int BTN_START       = 3;
    localparam int BTN_UP          = 4;
    localparam int BTN_DOWN        = 5;
    localparam int BTN_LEFT        = 6;
    localparam int BTN_RIGHT       = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_REPEAT  = 2'd2
    } evt_kind_t;

    // Packs a button index and event kind into an event word.
    function automatic logic [EVT_W-1:0] make_event(
        input logic [EVT_IDX_W-1:0] idx,
        input evt_kind_t            kind
    );
        logic [EVT_W-1:0] evt;
        evt                               = '0;
        evt[EVT_IDX_LSB +: EVT_IDX_W]     = idx;
        evt[EVT_RELEASE_BIT]              = (kind == EVT_RELEASE);
        evt[EVT_REPEAT_BIT]               = (kind == EVT_REPEAT);
        return evt;
    endfunction

endpackage

// File: rtl/mod_controller_events_fifo.sv
// mod_event_fifo
//   Parameterised synchronous FIFO with asynchronous active-high reset.
//   A push into a full FIFO is accepted when a pop happens in the same
//   cycle (the freed slot is reused on the same edge).
//   Ports:
//     clk, rst        clock, async active-high reset
//     push, push_data write request and data
//     pop             read request (ignored when empty)
//     pop_data        head entry (combinational read)
//     full, empty     occupancy flags
//     push_accepted   this cycle's push is being stored
module mod_event_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             push_accepted
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             pop_ok;
    logic             push_ok;

    assign empty         = (count_reg == '0);
    assign full          = (count_reg == (AW+1)'(DEPTH));
    assign pop_ok        = pop && !empty;
    assign push_ok       = push && (!full || pop_ok);
    assign push_accepted = push_ok;
    assign pop_data      = mem[rd_ptr_reg];

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mod_controller_events.sv
// mod_controller_events
//   Turns the NES button vector into discrete press / release / repeat
//   events, evaluated once per video frame (falling edge of vsync), and
//   queues them for a consumer using a valid/ready handshake.
//   Ports:
//     in_clk_12_mhz       system clock
//     in_reset            async active-high reset
//     in_vsync            VGA vsync (active low), asynchronous
//     in_buttons[7:0]     raw button levels (1 = pressed), asynchronous
//     in_event_ready      consumer accepts the head event
//     out_event_valid     event queue non-empty
//     out_event_data[4:0] head event {repeat, release, idx[2:0]}
//     out_buttons_stable  button vector sampled at the last frame tick
//     out_dropped_count   events lost to a full queue, saturating at 255
module mod_controller_events
    import mod_controller_events_pkg::*;
#(
    parameter int REPEAT_DELAY_FRAMES  = 24,
    parameter int REPEAT_PERIOD_FRAMES = 6,
    parameter int FIFO_DEPTH           = 4,
    parameter int SYNC_STAGES          = 2
) (
    input  logic             in_clk_12_mhz,
    input  logic             in_reset,
    input  logic             in_vsync,
    input  logic [7:0]       in_buttons,
    input  logic             in_event_ready,
    output logic             out_event_valid,
    output logic [EVT_W-1:0] out_event_data,
    output logic [7:0]       out_buttons_stable,
    output logic [7:0]       out_dropped_count
);

    localparam logic [7:0] DELAY_LOAD  = 8'(REPEAT_DELAY_FRAMES);
    localparam logic [7:0] PERIOD_LOAD = 8'(REPEAT_PERIOD_FRAMES);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] vsync_sync_reg;
    logic [7:0]             buttons_sync_reg [SYNC_STAGES];
    logic                   vsync_prev_reg;
    logic                   vsync_synced;
    logic [7:0]             buttons_synced;
    logic                   tick;

    always_ff @(posedge in_clk_12_mhz or posedge in_reset) begin
        if (in_reset) begin
            vsync_sync_reg      <= '0;
            buttons_sync_reg[0] <= '0;
        end else begin
            vsync_sync_reg      <= {vsync_sync_reg[SYNC_STAGES-2:0], in_vsync};
            buttons_sync_reg[0] <= in_buttons;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_btn_sync
            always_ff @(posedge in_clk_12_mhz or posedge in_reset) begin
                if (in_reset) begin
                    buttons_sync_reg[gi] <= '0;
                end else begin
                    buttons_sync_reg[gi] <= buttons_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign vsync_synced   = vsync_sync_reg[SYNC_STAGES-1];
    assign buttons_synced = buttons_sync_reg[SYNC_STAGES-1];

    // The previous-vsync flop resets to 0 so the idle-high vsync rising
    // out of reset is never mistaken for a frame start.
    always_ff @(posedge in_clk_12_mhz or posedge in_reset) begin
        if (in_reset) begin
            vsync_prev_reg <= 1'b0;
        end else begin
            vsync_prev_reg <= vsync_synced;
        end
    end

    assign tick = vsync_prev_reg && !vsync_synced;

    // ------------------------------------------------------------------
    // Scan FSM: one button per cycle after each frame tick
    // ------------------------------------------------------------------
    scan_state_t          state_reg,  state_next;
    logic [EVT_IDX_W-1:0] k_reg,      k_next;
    logic                 pending_reg, pending_next;
    logic [7:0]           pending_buttons_reg, pending_buttons_next;
    logic [7:0]           sample_reg, sample_next;
    logic [7:0]           prev_reg,   prev_next;
    logic [7:0]           stable_reg, stable_next;
    logic [7:0]           rpt_reg  [NUM_BUTTONS];
    logic [7:0]           rpt_next [NUM_BUTTONS];

    logic                 evt_push;
    logic [EVT_W-1:0]     evt_data;
    logic                 cur_level;
    logic                 old_level;

    always_ff @(posedge in_clk_12_mhz or posedge in_reset) begin
        if (in_reset) begin
            state_reg           <= ST_IDLE;
            k_reg               <= '0;
            pending_reg         <= 1'b0;
            pending_buttons_reg <= '0;
            sample_reg          <= '0;
            prev_reg            <= '0;
            stable_reg          <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                rpt_reg[i] <= '0;
            end
        end else begin
            state_reg           <= state_next;
            k_reg               <= k_next;
            pending_reg         <= pending_next;
            pending_buttons_reg <= pending_buttons_next;
            sample_reg          <= sample_next;
            prev_reg            <= prev_next;
            stable_reg          <= stable_next;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                rpt_reg[i] <= rpt_next[i];
            end
        end
    end

    assign cur_level = sample_reg[k_reg];
    assign old_level = prev_reg[k_reg];

    always_comb begin
        state_next           = state_reg;
        k_next               = k_reg;
        pending_next         = pending_reg;
        pending_buttons_next = pending_buttons_reg;
        sample_next          = sample_reg;
        prev_next            = prev_reg;
        stable_next          = stable_reg;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            rpt_next[i] = rpt_reg[i];
        end
        evt_push = 1'b0;
        evt_data = '0;

        // The visible snapshot follows every tick, including ones whose
        // scan is deferred or discarded.
        if (tick) begin
            stable_next = buttons_synced;
        end

        case (state_reg)
            ST_IDLE: begin
                if (pending_reg) begin
                    // Service the deferred frame with the buttons captured
                    // when its tick arrived; a tick landing on this same
                    // cycle becomes the new pending frame.
                    state_next   = ST_SCAN;
                    k_next       = '0;
                    sample_next  = pending_buttons_reg;
                    pending_next = tick;
                    if (tick) begin
                        pending_buttons_next = buttons_synced;
                    end
                end else if (tick) begin
                    state_next  = ST_SCAN;
                    k_next      = '0;
                    sample_next = buttons_synced;
                end
            end

            ST_SCAN: begin
                if (cur_level && !old_level) begin
                    evt_push        = 1'b1;
                    evt_data        = make_event(k_reg, EVT_PRESS);
                    rpt_next[k_reg] = DELAY_LOAD;
                end else if (!cur_level && old_level) begin
                    evt_push        = 1'b1;
                    evt_data        = make_event(k_reg, EVT_RELEASE);
                    rpt_next[k_reg] = '0;
                end else if (cur_level && old_level) begin
                    if (rpt_reg[k_reg] == 8'd1) begin
                        evt_push        = 1'b1;
                        evt_data        = make_event(k_reg, EVT_REPEAT);
                        rpt_next[k_reg] = PERIOD_LOAD;
                    end else if (rpt_reg[k_reg] > 8'd1) begin
                        rpt_next[k_reg] = rpt_reg[k_reg] - 8'd1;
                    end
                end

                if (k_reg == EVT_IDX_W'(NUM_BUTTONS - 1)) begin
                    state_next = ST_IDLE;
                    prev_next  = sample_reg;
                end else begin
                    k_next = k_reg + EVT_IDX_W'(1);
                end

                // Only one frame can wait behind the running scan.
                if (tick && !pending_reg) begin
                    pending_next         = 1'b1;
                    pending_buttons_next = buttons_synced;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Event queue and drop counter
    // ------------------------------------------------------------------
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push_accepted;
    logic             fifo_pop;
    logic [EVT_W-1:0] fifo_head;
    logic [7:0]       dropped_reg;

    assign fifo_pop = !fifo_empty && in_event_ready;

    mod_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk           (in_clk_12_mhz),
        .rst           (in_reset),
        .push          (evt_push),
        .push_data     (evt_data),
        .pop           (fifo_pop),
        .pop_data      (fifo_head),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .push_accepted (fifo_push_accepted)
    );

    always_ff @(posedge in_clk_12_mhz or posedge in_reset) begin
        if (in_reset) begin
            dropped_reg <= '0;
        end else if (evt_push && !fifo_push_accepted && (dropped_reg != 8'hFF)) begin
            dropped_reg <= dropped_reg + 8'd1;
        end
    end

    assign out_event_valid    = !fifo_empty;
    // Storage is not reset, so mask the head while nothing is queued.
    assign out_event_data     = fifo_empty ? '0 : fifo_head;
    assign out_buttons_stable = stable_reg;
    assign out_dropped_count  = dropped_reg;

endmodule

// File: tb/tb_mod_controller_events.sv
// Bench for mod_controller_events: a frame-level reference model plus
// directed scenarios with hand-computed event sequences.
module tb_mod_controller_events;

    localparam int S      = 2;
    localparam int D      = 4;
    localparam int DELAY  = 24;
    localparam int PERIOD = 6;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       vsync   = 1'b1;
    logic       ready   = 1'b0;
    logic [7:0] buttons = 8'h00;

    logic       out_event_valid;
    logic [4:0] out_event_data;
    logic [7:0] out_buttons_stable;
    logic [7:0] out_dropped_count;

    mod_controller_events #(
        .REPEAT_DELAY_FRAMES  (DELAY),
        .REPEAT_PERIOD_FRAMES (PERIOD),
        .FIFO_DEPTH           (D),
        .SYNC_STAGES          (S)
    ) dut (
        .in_clk_12_mhz      (clk),
        .in_reset           (rst),
        .in_vsync           (vsync),
        .in_buttons         (buttons),
        .in_event_ready     (ready),
        .out_event_valid    (out_event_valid),
        .out_event_data     (out_event_data),
        .out_buttons_stable (out_buttons_stable),
        .out_dropped_count  (out_dropped_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         cyc = 0;
    logic       hv[$];
    logic [7:0] hb[$];
    logic [7:0] m_prev;
    int         m_rpt[8];
    int         scan_end;
    bit         pend;
    logic [7:0] pend_btn;
    logic [7:0] m_stable;
    int         m_drop;
    logic [4:0] mq[$];
    int         sched_cyc[$];
    logic [4:0] sched_dat[$];
    logic [4:0] pop_log[$];

    function automatic void model_reset();
        hv.delete(); hb.delete();
        for (int i = 0; i <= S; i++) begin
            hv.push_back(1'b0);
            hb.push_back(8'h00);
        end
        m_prev = 8'h00;
        for (int i = 0; i < 8; i++) m_rpt[i] = 0;
        scan_end = -1;
        pend     = 1'b0;
        pend_btn = 8'h00;
        m_stable = 8'h00;
        m_drop   = 0;
        mq.delete(); sched_cyc.delete(); sched_dat.delete();
    endfunction

    // Evaluate a whole frame at once; event for button k lands in the
    // queue on the edge closing cycle c+1+k.
    function automatic void start_frame(input logic [7:0] b, input int c);
        for (int k = 0; k < 8; k++) begin
            logic [2:0] idx;
            idx = 3'(k);
            if (b[k] && !m_prev[k]) begin
                sched_cyc.push_back(c + 1 + k); sched_dat.push_back({2'b00, idx});
                m_rpt[k] = DELAY;
            end else if (!b[k] && m_prev[k]) begin
                sched_cyc.push_back(c + 1 + k); sched_dat.push_back({2'b01, idx});
                m_rpt[k] = 0;
            end else if (b[k] && m_prev[k]) begin
                if (m_rpt[k] == 1) begin
                    sched_cyc.push_back(c + 1 + k); sched_dat.push_back({2'b10, idx});
                    m_rpt[k] = PERIOD;
                end else if (m_rpt[k] > 1) begin
                    m_rpt[k] = m_rpt[k] - 1;
                end
            end
        end
        m_prev   = b;
        scan_end = c + 8;
    endfunction

    initial model_reset();

    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            chk("rst_valid",   {31'b0, out_event_valid}, 32'd0);
            chk("rst_data",    {27'b0, out_event_data},  32'd0);
            chk("rst_stable",  {24'b0, out_buttons_stable}, 32'd0);
            chk("rst_dropped", {24'b0, out_dropped_count},  32'd0);
        end else begin
            logic       tick;
            logic [7:0] sb;
            bit         popm;
            chk("valid",   {31'b0, out_event_valid}, {31'b0, (mq.size() > 0)});
            if (mq.size() > 0) chk("data", {27'b0, out_event_data}, {27'b0, mq[0]});
            chk("dropped", {24'b0, out_dropped_count},  32'(m_drop));
            chk("stable",  {24'b0, out_buttons_stable}, {24'b0, m_stable});
            if (out_event_valid && ready) pop_log.push_back(out_event_data);

            // advance the model across the coming rising edge
            tick = hv[S] && !hv[S-1];
            sb   = hb[S-1];
            if (tick) m_stable = sb;
            if (cyc > scan_end) begin
                if (pend) begin
                    start_frame(pend_btn, cyc);
                    pend = tick;
                    if (tick) pend_btn = sb;
                end else if (tick) begin
                    start_frame(sb, cyc);
                end
            end else if (tick && !pend) begin
                pend     = 1'b1;
                pend_btn = sb;
            end

            popm = (mq.size() > 0) && ready;
            if (popm) void'(mq.pop_front());
            if (sched_cyc.size() > 0 && sched_cyc[0] == cyc) begin
                logic [4:0] e;
                void'(sched_cyc.pop_front());
                e = sched_dat.pop_front();
                if (mq.size() < D) mq.push_back(e);
                else if (m_drop < 255) m_drop++;
            end

            hv.push_front(vsync); void'(hv.pop_back());
            hb.push_front(buttons); void'(hb.pop_back());
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int lo, input int hi);
        vsync = 1'b0;
        step(lo);
        vsync = 1'b1;
        step(hi);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(5);
        chk("idle_valid", {31'b0, out_event_valid}, 32'd0);

        // T1: single press of button 3
        buttons = 8'h08;
        step(4);
        frame(4, 16);
        chk("t1_valid",  {31'b0, out_event_valid}, 32'd1);
        chk("t1_head",   {27'b0, out_event_data},  32'h03);
        chk("t1_stable", {24'b0, out_buttons_stable}, 32'h08);
        pop_log.delete();
        ready = 1'b1;
        step(3);
        chk("t1_count", 32'(pop_log.size()), 32'd1);
        if (pop_log.size() > 0) chk("t1_pop", {27'b0, pop_log[0]}, 32'h03);
        buttons = 8'h00;
        step(4);
        frame(4, 16);

        // T2: hold button 0 for 40 frames, then release
        pop_log.delete();
        buttons = 8'h01;
        step(4);
        repeat (40) frame(4, 16);
        chk("t2_count", 32'(pop_log.size()), 32'd4);
        if (pop_log.size() == 4) begin
            chk("t2_press", {27'b0, pop_log[0]}, 32'h00);
            chk("t2_rpt25", {27'b0, pop_log[1]}, 32'h10);
            chk("t2_rpt31", {27'b0, pop_log[2]}, 32'h10);
            chk("t2_rpt37", {27'b0, pop_log[3]}, 32'h10);
        end
        buttons = 8'h00;
        step(4);
        frame(4, 16);
        chk("t2_count_rel", 32'(pop_log.size()), 32'd5);
        if (pop_log.size() == 5) chk("t2_release", {27'b0, pop_log[4]}, 32'h08);

        // T3: all buttons at once with consumer stalled
        ready   = 1'b0;
        buttons = 8'hFF;
        step(4);
        frame(4, 16);
        chk("t3_dropped", {24'b0, out_dropped_count}, 32'd4);
        chk("t3_head",    {27'b0, out_event_data},    32'h00);
        pop_log.delete();
        ready = 1'b1;
        step(6);
        ready = 1'b0;
        chk("t3_count", 32'(pop_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            chk("t3_order", {27'b0, pop_log[i]}, 32'(i));

        // T4: full queue, consumer pops while the scan pushes
        buttons = 8'h00;
        step(4);
        frame(4, 16);
        chk("t4_dropped_fill", {24'b0, out_dropped_count}, 32'd8);
        buttons = 8'h0F;
        step(4);
        pop_log.delete();
        vsync = 1'b0;
        step(3);
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("t4_valid_held", {31'b0, out_event_valid}, 32'd1);
            step(1);
        end
        vsync = 1'b1;
        step(12);
        chk("t4_no_drop", {24'b0, out_dropped_count}, 32'd8);
        chk("t4_count", 32'(pop_log.size()), 32'd8);
        if (pop_log.size() == 8) begin
            chk("t4_pop0", {27'b0, pop_log[0]}, 32'h08);
            chk("t4_pop3", {27'b0, pop_log[3]}, 32'h0B);
            chk("t4_pop4", {27'b0, pop_log[4]}, 32'h00);
            chk("t4_pop7", {27'b0, pop_log[7]}, 32'h03);
        end

        // T5: second vsync fall during the scan is serviced afterwards
        pop_log.delete();
        vsync = 1'b0;
        step(2);
        vsync   = 1'b1;
        buttons = 8'h1F;
        step(2);
        vsync = 1'b0;
        step(2);
        vsync = 1'b1;
        step(30);
        chk("t5_count", 32'(pop_log.size()), 32'd1);
        if (pop_log.size() > 0) chk("t5_pending_press", {27'b0, pop_log[0]}, 32'h04);
        chk("t5_stable", {24'b0, out_buttons_stable}, 32'h1F);

        // T6: reset in the middle of a scan with three events queued
        ready   = 1'b0;
        buttons = 8'h18;
        step(4);
        vsync = 1'b0;
        step(8);
        chk("t6_pre_valid",   {31'b0, out_event_valid},   32'd1);
        chk("t6_pre_dropped", {24'b0, out_dropped_count}, 32'd8);
        rst = 1'b1;
        step(1);
        chk("t6_valid",   {31'b0, out_event_valid},   32'd0);
        chk("t6_dropped", {24'b0, out_dropped_count}, 32'd0);
        step(2);
        rst   = 1'b0;
        vsync = 1'b1;
        step(4);
        pop_log.delete();
        ready = 1'b1;
        frame(4, 16);
        chk("t6_count", 32'(pop_log.size()), 32'd2);
        if (pop_log.size() == 2) begin
            chk("t6_press3", {27'b0, pop_log[0]}, 32'h03);
            chk("t6_press4", {27'b0, pop_log[1]}, 32'h04);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
